// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   kp_state_t - debounce FSM states (SCAN, DEBOUNCE, HELD)
//   KEYMAP     - key index (row*4 + col) to hex code
//   popcount16 / lowest_key - snapshot helpers used at scan end
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  // Index 0 is the rightmost entry: row 0 reads "1 2 3 A", row 3 reads "E 0 F D".
  localparam logic [NUM_KEYS-1:0][3:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [4:0] popcount16(input logic [NUM_KEYS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [3:0] lowest_key(input logic [NUM_KEYS-1:0] v);
    logic [3:0] k;
    logic       found;
    k     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i] && !found) begin
        k     = 4'(i);
        found = 1'b1;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner: drives the keypad rows one at a time and assembles a
// 16-bit snapshot of pressed keys (bit row*4 + col, active-high).
//   clk, rst_n - clock, asynchronous active-low reset
//   ena        - low clears the scan position and snapshot, rows undriven
//   col_in     - raw active-low column inputs (asynchronous)
//   row_out    - active-low one-hot row drive (4'hF when idle)
//   snapshot   - latest row samples, complete when scan_done is high
//   scan_done  - one-cycle pulse after row 3 has been latched
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [NUM_KEYS-1:0] snapshot,
  output logic                scan_done
);

  localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);

  logic [NUM_COLS-1:0] col_meta;
  logic [NUM_COLS-1:0] col_sync;
  logic [NUM_COLS-1:0] colp;
  logic [15:0]         dwell;
  logic [1:0]          row_idx;

  // Idle columns are pulled up, so the synchronizer resets to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign colp = ~col_sync;

  // row_out lags row_idx by one cycle and the synchronizer adds two more,
  // so sampling on the last dwell cycle sees this row's columns when
  // SCAN_DIV >= 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell     <= '0;
      row_idx   <= '0;
      row_out   <= '1;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else if (!ena) begin
      dwell     <= '0;
      row_idx   <= '0;
      row_out   <= '1;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      row_out   <= ~(4'b0001 << row_idx);
      scan_done <= 1'b0;
      if (dwell == SCAN_DIV - 16'd1) begin
        dwell                            <= '0;
        snapshot[{row_idx, 2'b00} +: 4]  <= colp;
        row_idx                          <= row_idx + 2'd1;
        scan_done                        <= (row_idx == LAST_ROW);
      end else begin
        dwell <= dwell + 16'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: 4x4 keypad scanner with press/release debouncing.
// Accepts a single key after DEBOUNCE_SCANS identical full scans, emits its
// hex code with a one-cycle valid strobe and holds off further reports until
// the keypad has been empty for DEBOUNCE_SCANS scans.
//   clk, rst_n - clock, asynchronous active-low reset
//   ena        - block enable; low pauses scanning and drops key_held
//   col_in     - keypad columns, active-low, asynchronous
//   row_out    - row drive, active-low one-hot
//   key_code   - hex code of the last accepted key
//   key_valid  - one-cycle pulse when key_code is updated
//   key_held   - high while the accepted key remains pressed
//   multi_key  - one-cycle pulse after any scan that saw more than one key
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV       = 16'd1000,
  parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  logic [NUM_KEYS-1:0] snapshot;
  logic                scan_done;

  kp_state_t  state;
  logic [3:0] cand;
  logic [3:0] stable_cnt;
  logic [3:0] rel_cnt;

  logic [4:0] pc;
  logic [3:0] key_idx;
  logic       cand_only;
  logic       accept;
  logic [3:0] accept_idx;

  keypad_row_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .col_in    (col_in),
    .row_out   (row_out),
    .snapshot  (snapshot),
    .scan_done (scan_done)
  );

  // Acceptance is shared between SCAN (single-scan debounce) and DEBOUNCE.
  always_comb begin
    pc         = popcount16(snapshot);
    key_idx    = lowest_key(snapshot);
    cand_only  = (snapshot == (16'd1 << cand));
    accept     = 1'b0;
    accept_idx = cand;
    if (scan_done) begin
      if (state == SCAN && pc == 5'd1 && DEBOUNCE_SCANS == 4'd1) begin
        accept     = 1'b1;
        accept_idx = key_idx;
      end else if (state == DEBOUNCE && cand_only &&
                   (stable_cnt + 4'd1) == DEBOUNCE_SCANS) begin
        accept     = 1'b1;
        accept_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      cand       <= '0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      multi_key  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_key <= 1'b0;
      if (!ena) begin
        state      <= SCAN;
        stable_cnt <= '0;
        rel_cnt    <= '0;
        key_held   <= 1'b0;
      end else if (scan_done) begin
        multi_key <= (pc > 5'd1);
        if (accept) begin
          key_code   <= KEYMAP[accept_idx];
          key_valid  <= 1'b1;
          key_held   <= 1'b1;
          stable_cnt <= '0;
          rel_cnt    <= '0;
          state      <= HELD;
        end else begin
          case (state)
            SCAN: begin
              if (pc == 5'd1) begin
                cand       <= key_idx;
                stable_cnt <= 4'd1;
                state      <= DEBOUNCE;
              end
            end
            DEBOUNCE: begin
              if (cand_only) begin
                stable_cnt <= stable_cnt + 4'd1;
              end else begin
                stable_cnt <= '0;
                state      <= SCAN;
              end
            end
            HELD: begin
              // Any key activity, even a different key, restarts the release count.
              if (snapshot == '0) begin
                if ((rel_cnt + 4'd1) == DEBOUNCE_SCANS) begin
                  key_held <= 1'b0;
                  rel_cnt  <= '0;
                  state    <= SCAN;
                end else begin
                  rel_cnt <= rel_cnt + 4'd1;
                end
              end else begin
                rel_cnt <= '0;
              end
            end
            default: state <= SCAN;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;

  localparam logic [15:0] SCAN_DIV = 16'd4;
  localparam int unsigned DSCANS   = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena   = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] pressed = '0;

  always #5 clk = ~clk;

  keypad_scan_debounce #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (4'(DSCANS))
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  // Physical keypad: a pressed key shorts its driven-low row onto its column.
  always_comb begin
    col_in = '1;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [3:0]  code;
    int unsigned cyc;
  } ev_t;

  ev_t         vq[$];
  int unsigned mq[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned vcount = 0;
  int unsigned mcount = 0;

  logic [3:0] hexmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  // ---------------- reference model ----------------
  int unsigned cyc = 0;
  int unsigned n = 0;
  logic [3:0]  rows_seen [4];
  logic        pend = 1'b0;
  logic        held = 1'b0;
  int unsigned run_len = 0;
  int unsigned run_key = 0;
  int unsigned rel_len = 0;
  logic [3:0]  exp_row  = 4'hF;
  logic        exp_held = 1'b0;
  logic [3:0]  exp_code = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    pend     = 1'b0;
    held     = 1'b0;
    run_len  = 0;
    rel_len  = 0;
    exp_row  = 4'hF;
    exp_held = 1'b0;
    exp_code = 4'h0;
  endtask

  // One complete scan: count runs of identical single-key scans while idle,
  // runs of empty scans while a key is held.
  task automatic evaluate();
    logic [15:0] snap;
    int unsigned pc;
    int unsigned idx;
    ev_t         e;
    snap = {rows_seen[3], rows_seen[2], rows_seen[1], rows_seen[0]};
    pc   = $countones(snap);
    idx  = 0;
    for (int unsigned i = 0; i < 16; i++) if (snap[i]) idx = i;
    if (pc > 1) mq.push_back(cyc);
    if (!held) begin
      if (run_len == 0) begin
        if (pc == 1) begin
          run_key = idx;
          run_len = 1;
        end
      end else if (pc == 1 && idx == run_key) begin
        run_len++;
      end else begin
        run_len = 0;
      end
      if (run_len == DSCANS) begin
        e.code   = hexmap[run_key];
        e.cyc    = cyc;
        vq.push_back(e);
        exp_code = e.code;
        exp_held = 1'b1;
        held     = 1'b1;
        run_len  = 0;
        rel_len  = 0;
      end
    end else begin
      if (pc == 0) begin
        rel_len++;
        if (rel_len == DSCANS) begin
          held     = 1'b0;
          exp_held = 1'b0;
          rel_len  = 0;
        end
      end else begin
        rel_len = 0;
      end
    end
  endtask

  // Edge n after enable: row (n/4)%4 is driven; its columns reach the
  // snapshot as seen at edge n%4==1; the full scan is evaluated one edge
  // after n%16==15.
  initial begin : model
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
      end else if (!ena) begin
        n        = 0;
        pend     = 1'b0;
        held     = 1'b0;
        run_len  = 0;
        rel_len  = 0;
        exp_row  = 4'hF;
        exp_held = 1'b0;
      end else begin
        if (pend) begin
          pend = 1'b0;
          evaluate();
        end
        if (n % 4 == 1) rows_seen[(n/4)%4] = pressed[((n/4)%4)*4 +: 4];
        if (n % 16 == 15) pend = 1'b1;
        exp_row = ~(4'b0001 << ((n/4)%4));
        n++;
      end
    end
  end

  initial begin : model_async_reset
    forever begin
      @(negedge rst_n);
      model_reset();
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      chk("row_out", 32'(row_out), 32'(exp_row));
      chk("key_held", 32'(key_held), 32'(exp_held));
      chk("key_code", 32'(key_code), 32'(exp_code));
      while (vq.size() > 0 && vq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL key_valid_missing: got none expected pulse code %0h at cycle %0d", vq[0].code, vq[0].cyc);
        void'(vq.pop_front());
      end
      while (mq.size() > 0 && mq[0] < cyc) begin
        checks++; errors++;
        $display("FAIL multi_key_missing: got none expected pulse at cycle %0d", mq[0]);
        void'(mq.pop_front());
      end
      if (key_valid) begin
        vcount++;
        if (vq.size() == 0) begin
          checks++; errors++;
          $display("FAIL key_valid_unexpected: got pulse code %0h expected none (cycle %0d)", key_code, cyc);
        end else begin
          e = vq.pop_front();
          chk("key_valid_cycle", e.cyc == cyc ? 32'(cyc) : 32'(e.cyc) + 32'd1000000, 32'(e.cyc));
          chk("key_valid_code", 32'(key_code), 32'(e.code));
        end
      end
      if (multi_key) begin
        mcount++;
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL multi_key_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          chk("multi_key_cycle", 32'(cyc), 32'(mq.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int unsigned k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic tap(input int unsigned k, input int unsigned hold, input int unsigned rel);
    pressed = 16'(1 << k);
    tick(hold);
    pressed = '0;
    tick(rel);
  endtask

  initial begin : stim
    int unsigned v0;
    int unsigned m0;
    #1 rst_n = 1'b0;
    tick(5);
    chk("reset_row_out", 32'(row_out), 32'hF);
    chk("reset_key_code", 32'(key_code), 32'h0);
    chk("reset_key_valid", 32'(key_valid), 32'h0);
    chk("reset_key_held", 32'(key_held), 32'h0);
    chk("reset_multi_key", 32'(multi_key), 32'h0);

    rst_n = 1'b1;
    ena   = 1'b1;
    tick(40);

    // Clean press '6'
    v0 = vcount;
    pressed = 16'h0040;
    tick(120);
    chk("press6_valid_count", vcount - v0, 1);
    chk("press6_code", 32'(key_code), 32'h6);
    chk("press6_held", 32'(key_held), 32'h1);
    pressed = '0;
    tick(80);
    chk("release6_held", 32'(key_held), 32'h0);
    chk("release6_valid_count", vcount - v0, 1);

    // Bouncing '9'
    v0 = vcount;
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) pressed[10] = ~pressed[10];
      tick(1);
    end
    pressed = 16'h0400;
    tick(100);
    chk("bounce9_valid_count", vcount - v0, 1);
    chk("bounce9_code", 32'(key_code), 32'h9);
    pressed = '0;
    tick(80);

    // '1' and 'A' together, then 'A' released
    v0 = vcount;
    m0 = mcount;
    pressed = 16'h0009;
    tick(100);
    chk("twokey_valid_count", vcount - v0, 0);
    chk("twokey_multi_enough", 32'(mcount - m0 >= 5), 32'h1);
    pressed = 16'h0001;
    tick(100);
    chk("after_multi_valid_count", vcount - v0, 1);
    chk("after_multi_code", 32'(key_code), 32'h1);
    pressed = '0;
    tick(80);

    // '*', '#', '0'
    v0 = vcount; tap(12, 100, 80);
    chk("star_count", vcount - v0, 1);
    chk("star_code", 32'(key_code), 32'hE);
    v0 = vcount; tap(14, 100, 80);
    chk("hash_count", vcount - v0, 1);
    chk("hash_code", 32'(key_code), 32'hF);
    v0 = vcount; tap(13, 100, 80);
    chk("zero_count", vcount - v0, 1);
    chk("zero_code", 32'(key_code), 32'h0);

    // Random presses, some too short, some with a second key glitch
    for (int i = 0; i < 10; i++) begin
      int unsigned k;
      int unsigned hold;
      k    = $urandom_range(0, 15);
      hold = $urandom_range(20, 130);
      pressed = 16'(1 << k);
      if ($urandom_range(0, 3) == 0) begin
        tick(hold / 2);
        pressed[$urandom_range(0, 15)] = 1'b1;
        tick($urandom_range(5, 30));
        pressed = 16'(1 << k);
        tick(hold / 2);
      end else begin
        tick(hold);
      end
      pressed = '0;
      tick($urandom_range(30, 90));
    end
    tick(80);

    // Reset while debouncing '5' after '2' has been accepted
    tap(1, 100, 80);
    chk("pre_reset_code", 32'(key_code), 32'h2);
    v0 = vcount;
    pressed = 16'h0020;
    tick(36);
    rst_n = 1'b0;
    #1;
    chk("async_reset_row_out", 32'(row_out), 32'hF);
    chk("async_reset_key_code", 32'(key_code), 32'h0);
    chk("async_reset_key_valid", 32'(key_valid), 32'h0);
    chk("async_reset_key_held", 32'(key_held), 32'h0);
    pressed = '0;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    chk("reset_no_valid", vcount - v0, 0);

    // Enable dropped while '7' is held
    pressed = 16'h0100;
    tick(100);
    chk("held7_held", 32'(key_held), 32'h1);
    ena = 1'b0;
    tick(1);
    chk("ena_off_row_out", 32'(row_out), 32'hF);
    chk("ena_off_key_held", 32'(key_held), 32'h0);
    chk("ena_off_key_code", 32'(key_code), 32'h7);
    tick(10);
    pressed = '0;
    ena = 1'b1;
    tick(80);

    chk("valid_queue_drained", vq.size(), 0);
    chk("multi_queue_drained", mq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream front-end for the keypad-to-register datapath. Drives a 4x4 matrix keypad row by row and samples its columns.
- Debounces a single key press and delivers a hex key code with a one-cycle valid strobe to the keypad encoder and register-bank write path.
- Rejects multi-key presses and suppresses auto-repeat until the key is released.

Parameters:
- SCAN_DIV, 16'd1000: clock cycles each row is driven. Must be >= 4.
- DEBOUNCE_SCANS, 4'd4: consecutive identical full scans required to accept a press or a release. Must be >= 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable. Low pauses scanning.
- col_in  input  4  keypad columns, active-low (pulled up externally), asynchronous
- row_out  output  4  row drive, active-low one-hot
- key_code  output  4  hex code of last accepted key
- key_valid  output  1  one-cycle pulse when key_code is updated
- key_held  output  1  high while the accepted key remains pressed
- multi_key  output  1  one-cycle pulse at end of any scan that saw more than one key

Behaviour:
- Reset (async, rst_n=0):
  - row_out=4'hF, key_code=0, key_valid=0, key_held=0, multi_key=0.
  - Row index 0, dwell counter 0, FSM=SCAN, debounce counters 0.
- Input sync: col_in passes through a 2-flop synchronizer, then is inverted to active-high (colp).
- Scan timing:
  - When ena=1, row_out is registered as ~(1<<row_idx).
  - The dwell counter counts 0..SCAN_DIV-1. On SCAN_DIV-1, colp is latched into snapshot bits [row_idx*4 +: 4] and row_idx increments mod 4.
  - Scan end is the cycle in which row 3 is latched. Scan period is 4*SCAN_DIV cycles.
- Key numbering: k = row*4 + col. Hex map, rows 0..3 left to right:
  - 1 2 3 A
  - 4 5 6 B
  - 7 8 9 C
  - E 0 F D ('*'=E, '#'=F)
- At scan end the FSM evaluates the 16-bit snapshot. popcount is computed over the full snapshot.
- FSM states:
  - SCAN:
    - popcount==1: cand<=k, stable_cnt<=1, go DEBOUNCE.
    - If DEBOUNCE_SCANS==1, accept immediately instead (same as the acceptance rule below).
    - Otherwise stay in SCAN.
  - DEBOUNCE:
    - Snapshot == only cand: stable_cnt++.
    - When stable_cnt reaches DEBOUNCE_SCANS: key_code<=map(cand), key_valid=1 for the next cycle only, key_held<=1, rel_cnt<=0, go HELD.
    - Any other snapshot: stable_cnt<=0, go SCAN.
  - HELD:
    - Snapshot empty: rel_cnt++. At DEBOUNCE_SCANS: key_held<=0, go SCAN.
    - Any non-empty snapshot (including a different key): rel_cnt<=0, stay HELD.
    - No rollover: a second key is never reported while in HELD.
- multi_key pulses for one cycle at any scan end with popcount>1, in any state.
- Accept latency: from the first scan that sees the key alone, DEBOUNCE_SCANS scan ends, plus 1 cycle to key_valid. key_code is stable from the key_valid cycle until the next acceptance.
- ena=0:
  - row_out<=4'hF. Dwell counter, row_idx and snapshot are cleared.
  - FSM<=SCAN, key_held<=0, no pulses. key_code is retained.
  - Scanning resumes at row 0 when ena returns.
- Reset mid-debounce or mid-HELD: everything returns immediately to reset values and no key_valid is emitted.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD)
  - the 16-entry KEYMAP constant
  - NUM_ROWS=4, NUM_COLS=4
- Sub-module keypad_row_scanner contains:
  - the synchronizer
  - the dwell counter
  - row_idx and the row_out register
  - the snapshot register
  - a one-cycle scan_done output
- The top level holds the FSM, popcount, debounce counters and outputs.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 cycles):
- Reset/scan: hold rst_n=0 -> row_out=4'hF and all outputs 0. Release with ena=1 -> row_out steps 1110, 1101, 1011, 0111, each for 4 cycles, then repeats.
- Clean press '6' (row1,col2 low while row1 driven) for 120 cycles -> exactly one key_valid, key_code=4'h6, key_held=1. Release -> key_held falls after 3 empty scan ends, with no further key_valid.
- Bounce: '9' toggles every 7 cycles for 60 cycles, then stays stable -> exactly one key_valid with key_code=4'h9, none during the bounce.
- Two keys '1' and 'A' held together -> no key_valid, multi_key pulses once per scan end. Release 'A' -> '1' is accepted, key_code=4'h1.
- Mapping: press '*', '#', '0' in turn with releases between -> key_code E, F, 0 respectively, one key_valid each.
- Disruption:
  - rst_n pulsed low during DEBOUNCE -> outputs 0 immediately, no key_valid.
  - ena=0 during HELD -> row_out=4'hF, key_held=0, key_code retained.
